// File: rtl/mem_responder.sv
// Word-addressed backing memory for the data-cache refill/write path.
// Serves one request at a time after a fixed latency and answers with a one-cycle response pulse.
module mem_responder #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        busy
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = DATA_W / 8;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;
   localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [BE_W-1:0]     be_q, be_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                ready_q, ready_d;
   logic                valid_q, valid_d;
   logic                access_c;
   logic [DATA_W-1:0]   merged_c;
   logic                unused_addr_c;

   logic [DATA_W-1:0]   mem [DEPTH];

   // Byte-offset and alias bits of the address carry no information here.
   assign unused_addr_c = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

   // Lane-wise merge of latched write data over the stored word.
   always_comb begin
      merged_c = mem[addr_q];
      for (int i = 0; i < int'(BE_W); i++) begin
         if (be_q[i]) merged_c[8*i +: 8] = wdata_q[8*i +: 8];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      addr_d   = addr_q;
      be_d     = be_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      access_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               we_d    = req_we;
               addr_d  = req_addr[ADDR_W+1:2];
               be_d    = req_be;
               wdata_d = req_wdata;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               access_c = 1'b1;
               rdata_d  = we_q ? merged_c : mem[addr_q];
               state_d  = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
      valid_d = (state_d == RESP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
      end
   end

   // Storage is never cleared; reset only suppresses a pending commit.
   always_ff @(posedge clk) begin
      if (!rst && access_c && we_q) mem[addr_q] <= merged_c;
   end

   assign req_ready  = ready_q;
   assign busy       = ~ready_q;
   assign resp_valid = valid_q;
   assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized bench for mem_responder against a word-array model.
module tb_mem_responder;

   localparam int L  = 4;
   localparam int AW = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [3:0]  req_be = '0;
   logic [31:0] req_wdata = '0;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        busy;

   int checks = 0;
   int errors = 0;
   logic [31:0] model [int];

   mem_responder #(.ADDR_W(AW), .LATENCY(L)) dut (
      .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_be(req_be), .req_wdata(req_wdata), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int word_of(input logic [31:0] a);
      return int'(a >> 2) % (1 << AW);
   endfunction

   // One request: returns the response word and checks latency, pulse count and idle return.
   task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd, input bit poke,
                      output logic [31:0] rd);
      int w, seen, pulses;
      logic [31:0] exp;
      w = word_of(addr);
      exp = model.exists(w) ? model[w] : 32'h0;
      if (we) begin
         for (int i = 0; i < 4; i++) if (be[i]) exp[8*i +: 8] = wd[8*i +: 8];
         model[w] = exp;
      end
      @(negedge clk);
      chk({tag, "_ready_pre"}, 32'(req_ready), 32'd1);
      req = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
      @(negedge clk);
      req = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_be = 4'($urandom); req_wdata = $urandom;
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      seen = -1; pulses = 0; rd = 'x;
      for (int k = 1; k <= L + 4; k++) begin
         @(negedge clk);
         if (resp_valid) begin
            pulses++;
            if (seen < 0) begin seen = k; rd = resp_rdata; end
         end
         if (poke && k == 1) begin
            req = 1'b1; req_we = 1'b1; req_be = 4'hF; req_wdata = $urandom;
         end
         if (k == 2) req = 1'b0;
      end
      chk({tag, "_latency"}, 32'(seen), 32'(L));
      chk({tag, "_pulses"}, 32'(pulses), 32'd1);
      chk({tag, "_rdata"}, rd, exp);
      chk({tag, "_rdata_hold"}, resp_rdata, exp);
      chk({tag, "_ready_post"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      logic [31:0] rd;
      int wl [8];
      int pulses;
      int w;

      // Reset and idle
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;

      // Full write then read with ignored low bits
      txn("wr_full", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, rd);
      chk("wr_full_const", rd, 32'hDEADBEEF);
      txn("rd_lowbits", 1'b0, 32'h12, 4'h0, 32'h0, 1'b0, rd);
      chk("rd_lowbits_const", rd, 32'hDEADBEEF);

      // Byte-masked write
      txn("wr_mask", 1'b1, 32'h10, 4'b0101, 32'h11223344, 1'b0, rd);
      chk("wr_mask_const", rd, 32'hDE22BE44);
      txn("rd_mask", 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, rd);
      chk("rd_mask_const", rd, 32'hDE22BE44);

      // Request during WAIT ignored, aliasing, empty byte mask
      txn("poke", 1'b1, 32'h1010, 4'hF, 32'hA5A55A5A, 1'b1, rd);
      txn("alias_rd", 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, rd);
      chk("alias_const", rd, 32'hA5A55A5A);
      txn("be0", 1'b1, 32'h10, 4'h0, 32'hFFFFFFFF, 1'b0, rd);
      chk("be0_const", rd, 32'hA5A55A5A);

      // Reset during WAIT abandons the write
      txn("preload", 1'b1, 32'h20, 4'hF, 32'h12345678, 1'b0, rd);
      @(negedge clk);
      req = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_be = 4'hF; req_wdata = 32'hCAFEF00D;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_ready", 32'(req_ready), 32'd1);
      chk("midrst_rdata", resp_rdata, 32'd0);
      pulses = 0;
      for (int k = 0; k < L + 3; k++) begin
         @(negedge clk);
         if (resp_valid) pulses++;
      end
      chk("midrst_no_resp", 32'(pulses), 32'd0);
      txn("midrst_rd", 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, rd);
      chk("midrst_rd_const", rd, 32'h12345678);

      // Back-to-back reads with req held high
      @(negedge clk);
      for (int j = 0; j <= 2 * L + 5; j++) begin
         if (j > 0) @(negedge clk);
         chk($sformatf("b2b_ready_%0d", j), 32'(req_ready),
             32'((j == 0) || (j == L + 2) || (j >= 2 * L + 4)));
         chk($sformatf("b2b_valid_%0d", j), 32'(resp_valid),
             32'((j - 1 == L) || (j - 1 == 2 * L + 2)));
         if (j - 1 == L) chk("b2b_rdata0", resp_rdata, model[word_of(32'h10)]);
         if (j - 1 == 2 * L + 2) chk("b2b_rdata1", resp_rdata, model[word_of(32'h20)]);
         if (j == 0) begin req = 1'b1; req_we = 1'b0; req_addr = 32'h10; end
         if (j == 1) req_addr = 32'h20;
         if (j == L + 3) req = 1'b0;
      end

      // Randomized traffic over a set of initialized words
      for (int i = 0; i < 8; i++) begin
         wl[i] = int'($urandom_range((1 << AW) - 1));
         txn("rnd_init", 1'b1, 32'(wl[i]) << 2, 4'hF, $urandom, 1'b0, rd);
      end
      for (int i = 0; i < 24; i++) begin
         w = wl[$urandom_range(7)];
         txn("rnd", 1'($urandom), {20'($urandom), 10'(w), 2'($urandom)}, 4'($urandom),
             $urandom, 1'($urandom), rd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
# mem_responder

Backing-memory responder on the memory side of the data-cache refill/write path in the pipelined CPU. It accepts one word request at a time from the cache controller over a req/ready handshake, waits a fixed number of cycles to model main-memory latency, and then performs the read or byte-masked write. It returns the result with a one-cycle response pulse. It is the memory end of the interface whose other end is the cache's refill (`RAM_out`) and write-through traffic.

## Interface
- `ADDR_W`, default 10: word-address bits; memory depth is 2**ADDR_W 32-bit words.
- `LATENCY`, default 4: number of wait cycles between acceptance and access. Legal range is ≥1.
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `req` in 1: request valid from the cache.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 32: byte address. Bits [1:0] are ignored. Bits [ADDR_W+1:2] select the word. Higher bits are ignored, so addresses alias.
- `req_be` in 4: write byte enables; lane i covers data bits [8i+7:8i] (little-endian, same as cache lanes). Ignored on reads.
- `req_wdata` in 32: write data.
- `req_ready` out 1: responder idle and able to accept.
- `resp_valid` out 1: one-cycle pulse marking completion.
- `resp_rdata` out 32: read result, or merged word after a write. Valid while `resp_valid` is high and held afterwards.
- `busy` out 1: equals `~req_ready`.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - WAIT: counter `cnt` in use.
  - RESP: `resp_valid`=1.
- Acceptance:
  - A request is accepted on an edge where the state is IDLE and `req`=1.
  - On that edge, latch `req_we`, word address, `req_be` and `req_wdata`, load `cnt`=LATENCY-1, and go to WAIT.
- WAIT:
  - If `cnt`≠0, decrement `cnt` on each edge.
  - On the edge where `cnt`=0, perform the access and go to RESP.
  - Read access: `resp_rdata` ← mem[word].
  - Write access: each lane with be=1 takes the latched wdata byte; lanes with be=0 keep the old byte. Write the merged word to mem[word], and `resp_rdata` ← merged word.
- RESP: lasts exactly one cycle, then return to IDLE unconditionally.
- `req` in any state other than IDLE is ignored. There is no queuing, and the latched request is not modified.
- A write with `req_be`=0000 still completes the handshake. Memory is unchanged, and `resp_rdata` = current word.
- Reset:
  - Reset values: state=IDLE, `cnt`=0, `resp_valid`=0, `resp_rdata`=0, `req_ready`=1, `busy`=0.
  - Memory contents are not cleared and are undefined until written.
  - Reset asserted during WAIT abandons the request. A write whose access edge has not yet occurred is not committed.
  - Reset during RESP drops `resp_valid` on that edge.
  - Reset wins over a same-edge acceptance or access.

## Timing
- If a request is accepted at edge E:
  - WAIT occupies LATENCY cycles.
  - The access happens at edge E+LATENCY.
  - `resp_valid` is high in the cycle after edge E+LATENCY and low after edge E+LATENCY+1.
  - `req_ready` returns high after edge E+LATENCY+1.
- Maximum throughput is one request per LATENCY+2 cycles. A request held high continuously is accepted at E, E+LATENCY+2, and so on.
- `req_ready` is driven from a registered state only and does not depend combinationally on `req`.
- `resp_rdata` changes only on access edges and reset.

## Test plan
- Reset then idle, LATENCY=4: hold `rst` 2 cycles -> `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `busy`=0.
- Full-word write then read:
  - Write addr 0x0000_0010, be=1111, data 0xDEADBEEF accepted at edge 0 -> `resp_valid` pulse in the cycle after edge 4, `resp_rdata`=0xDEADBEEF.
  - Read of 0x0000_0012 then returns 0xDEADBEEF, because bits [1:0] are ignored.
- Byte-masked write: over word 0xDEADBEEF at 0x10, write be=0101, data 0x11223344 -> `resp_rdata`=0xDE22BE44, and a later read returns 0xDE22BE44.
- Busy and aliasing:
  - A `req` pulse during WAIT is ignored: exactly one `resp_valid` pulse occurs.
  - With ADDR_W=10, a write to 0x0000_1010 followed by a read of 0x0000_0010 returns the written data.
- Reset mid-write: write 0xCAFEF00D to 0x20 and assert `rst` at edge 2 of WAIT -> no `resp_valid`. A read of 0x20 then returns the prior value (preload 0x12345678).
- Back-to-back: hold `req`=1 for two reads -> acceptances at edges 0 and 6, `resp_valid` after edges 4 and 10.
